// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI response codes and command-master FSM states
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding command to AXI-Lite master bridge
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    m3_axi_aclk,
  input  logic                    m3_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m3_axi_awaddr,
  output logic                    m3_axi_awvalid,
  input  logic                    m3_axi_awready,
  output logic [DATA_WIDTH-1:0]   m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m3_axi_wstrb,
  output logic                    m3_axi_wvalid,
  input  logic                    m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m3_axi_bresp,
  input  logic                    m3_axi_bvalid,
  output logic                    m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m3_axi_araddr,
  output logic                    m3_axi_arvalid,
  input  logic                    m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m3_axi_rresp,
  input  logic                    m3_axi_rvalid,
  output logic                    m3_axi_rready
);

  state_t                state, state_nxt;
  logic                  ready_en;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done, w_done;
  logic                  accept, misaligned, aw_hs, w_hs;

  assign accept     = cmd_valid && cmd_ready;
  assign misaligned = |cmd_addr[1:0];
  assign aw_hs      = m3_axi_awvalid && m3_axi_awready;
  assign w_hs       = m3_axi_wvalid && m3_axi_wready;

  // ready_en keeps cmd_ready low while reset is held and rises on the first edge after release
  assign cmd_ready      = (state == IDLE) && ready_en;
  assign rsp_valid      = (state == RSP);
  assign m3_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign m3_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign m3_axi_bready  = (state == WR_RESP);
  assign m3_axi_arvalid = (state == RD_REQ);
  assign m3_axi_rready  = (state == RD_DATA);
  assign m3_axi_awaddr  = addr_q;
  assign m3_axi_araddr  = addr_q;
  assign m3_axi_wdata   = wdata_q;
  assign m3_axi_wstrb   = '1;

  always_ff @(posedge m3_axi_aclk or negedge m3_axi_aresetn) begin
    if (!m3_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)     state_nxt = RSP;
          else if (cmd_write) state_nxt = WR_REQ;
          else                state_nxt = RD_REQ;
        end
      end
      // aw and w complete independently; leave once both have handshaked
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (m3_axi_bvalid) state_nxt = RSP;
      RD_REQ:  if (m3_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (m3_axi_rvalid) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m3_axi_aclk or negedge m3_axi_aresetn) begin
    if (!m3_axi_aresetn) begin
      ready_en  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        rsp_rdata <= '0;
        rsp_resp  <= misaligned ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == WR_RESP && m3_axi_bvalid) begin
        rsp_rdata <= '0;
        rsp_resp  <= m3_axi_bresp;
      end
      if (state == RD_DATA && m3_axi_rvalid) begin
        rsp_rdata <= m3_axi_rdata;
        rsp_resp  <= m3_axi_rresp;
      end
    end
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master
Interface
REQ-001 DATA_WIDTH, 32, AXI data and command data width; byte strobe width is DATA_WIDTH/8.
REQ-002 ADDR_WIDTH, 8, AXI and command address width.
REQ-003 RESP_WIDTH, 3, AXI response width; bits [1:0] carry the AXI code, upper bits zero.
REQ-004 m3_axi_aclk  in  1  single clock; all logic is rising-edge.
REQ-005 m3_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command request valid.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response valid; held until rsp_ready.
REQ-012 rsp_ready  in  1  response consumer ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; zero for writes and local errors.
REQ-014 rsp_resp  out  RESP_WIDTH  captured bresp/rresp, or local error code.
REQ-015 m3_axi_awaddr  out  ADDR_WIDTH  write address.
REQ-016 m3_axi_awvalid  out  1  write address valid.
REQ-017 m3_axi_awready  in  1  write address ready.
REQ-018 m3_axi_wdata  out  DATA_WIDTH  write data.
REQ-019 m3_axi_wstrb  out  DATA_WIDTH/8  byte strobes, driven all-ones.
REQ-020 m3_axi_wvalid  out  1  write data valid.
REQ-021 m3_axi_wready  in  1  write data ready.
REQ-022 m3_axi_bresp  in  RESP_WIDTH  write response.
REQ-023 m3_axi_bvalid  in  1  write response valid.
REQ-024 m3_axi_bready  out  1  write response ready.
REQ-025 m3_axi_araddr  out  ADDR_WIDTH  read address.
REQ-026 m3_axi_arvalid  out  1  read address valid.
REQ-027 m3_axi_arready  in  1  read address ready.
REQ-028 m3_axi_rdata  in  DATA_WIDTH  read data.
REQ-029 m3_axi_rresp  in  RESP_WIDTH  read response.
REQ-030 m3_axi_rvalid  in  1  read data valid.
REQ-031 m3_axi_rready  out  1  read data ready.
Function
REQ-032 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; cmd_ready SHALL be 1 only in IDLE, so there is at most one outstanding transaction.
REQ-033 When IDLE and cmd_valid is high: address and data are registered. If cmd_addr[1:0] is nonzero, go to RSP with rsp_resp=2 (SLVERR) and no bus activity. Otherwise go to WR_REQ (write) or RD_REQ (read).
REQ-034 WR_REQ: awvalid and wvalid assert on the cycle after acceptance. Each deasserts independently the cycle after its own handshake, and the address and data stay stable while valid. When both handshakes are done (including the same cycle), go to WR_RESP.
REQ-035 WR_RESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RSP. Minimum write latency is cmd accept at N, aw/w valid at N+1, bready at N+2, rsp_valid at N+3.
REQ-036 RD_REQ: arvalid is held until arready, then go to RD_DATA with rready=1. On rvalid, capture rdata and rresp, go to RSP. Minimum read latency is 3 cycles, accept to rsp_valid.
REQ-037 RSP: rsp_valid=1 and outputs stable until rsp_ready, then go to IDLE; cmd_ready rises the following cycle.
REQ-038 AXI valids SHALL never depend combinationally on readies, and SHALL never drop before their handshake.
Reset
REQ-039 On m3_axi_aresetn low, at any time including mid-transaction: state becomes IDLE, and all valid/ready outputs, rsp_rdata, rsp_resp, awaddr, araddr and wdata become 0. After release, cmd_ready=1 on the first clock edge.
Structure
REQ-040 A shared package axil_pkg SHALL hold the response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the FSM state enumeration.
REQ-041 The block SHALL be a single flat module with no sub-modules.
Verification
REQ-042 Write addr 0x04, data 23 to a slave with awready and wready tied high and OKAY response: awvalid and wvalid are seen for 1 cycle, rsp_valid appears 3 cycles after accept, rsp_resp=0.
REQ-043 Write with awready delayed 3 cycles and wready immediate: wvalid drops first, and awaddr 0x00 is held stable until its handshake.
REQ-044 Read addr 0x04 after writing 30 there: rsp_rdata=30, rsp_resp=0. Slave returns DECERR: rsp_resp=3.
REQ-045 cmd_addr=0x06: no AXI valid ever rises, rsp_resp=2 the cycle after accept. rsp_ready held low 5 cycles: rsp_valid stays high and outputs stay stable.
REQ-046 Assert reset while in WR_RESP with bvalid low: all outputs are 0 immediately. After release, a read at 0x00 completes normally.
